// File: rtl/uart_frame_pkg.sv
// Shared constants, write-FSM state type and elaboration helpers for the
// UART-to-frame-buffer path.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_MARKER = 8'hFF;
  localparam int GUARD_HI = 7;
  localparam int GUARD_LO = 0;

  typedef enum logic {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } wr_state_t;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/frame_read_addr_gen.sv
// VGA-side read path: window test, upscale shift, buffer address and a
// window flag pipelined alongside the 1-cycle synchronous RAM read.
module frame_read_addr_gen
  import uart_frame_pkg::*;
#(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int SCALE      = 1,
  parameter int COL_MAJOR  = 1,
  parameter int ADDR_W     = 18,
  parameter int COORD_W    = 11,
  parameter int PIXEL_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_BITS-1:0] rd_data,
  output logic [PIXEL_BITS-1:0] pix_out
);

  localparam int SHIFT = clog2_int(SCALE);
  localparam logic [COORD_W:0]  LIM_X = (COORD_W + 1)'(FRAME_W * SCALE);
  localparam logic [COORD_W:0]  LIM_Y = (COORD_W + 1)'(FRAME_H * SCALE);
  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(FRAME_H);

  logic                 in_win;
  logic [COORD_W-1:0]   sx_p0, sy_p0;
  logic [ADDR_W-1:0]    sx_a, sy_a, addr_p0;
  logic                 vld_p0, vld_p1, vld_p2;

  assign in_win = ({1'b0, pix_x} < LIM_X) && ({1'b0, pix_y} < LIM_Y);

  // stage p0: sample VGA position, reduce to source coordinates
  always_ff @(posedge clk) begin
    sx_p0 <= pix_x >> SHIFT;
    sy_p0 <= pix_y >> SHIFT;
  end

  assign sx_a    = ADDR_W'(sx_p0);
  assign sy_a    = ADDR_W'(sy_p0);
  assign addr_p0 = (COL_MAJOR != 0) ? (sx_a * H_A + sy_a) : (sy_a * W_A + sx_a);

  // stage p1: address to RAM; p2: RAM data returns; p3: gated colour out
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      rd_addr <= '0;
      pix_out <= '0;
    end else begin
      vld_p0  <= in_win;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      rd_addr <= vld_p0 ? addr_p0 : '0;
      pix_out <= vld_p2 ? rd_data : '0;
    end
  end

endmodule

// File: rtl/uart_frame_writer.sv
// Packs guarded UART payload bytes into pixels and writes a double-banked
// frame buffer; UART_FRAME_SYNC_EN adds the 8'hFF frame-marker resync.
module uart_frame_writer
  import uart_frame_pkg::*;
#(
  parameter int PIXEL_BITS   = 12,
  parameter int PAYLOAD_BITS = 6,
  parameter int FRAME_W      = 320,
  parameter int FRAME_H      = 240,
  parameter int SCALE        = 1,
  parameter int COL_MAJOR    = 1,
  parameter int ADDR_W       = 18,
  parameter int COORD_W      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIXEL_BITS-1:0] wr_data,
  output logic                  frame_done,
  output logic                  guard_err,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  output logic                  rd_bank,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_BITS-1:0] rd_data,
  output logic [PIXEL_BITS-1:0] pix_out
);

  localparam int BPP     = ceil_div(PIXEL_BITS, PAYLOAD_BITS);
  localparam int ACC_W   = BPP * PAYLOAD_BITS;
  localparam int PHASE_W = (BPP > 1) ? clog2_int(BPP) : 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BPP - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(FRAME_W * FRAME_H - 1);

  logic [PAYLOAD_BITS-1:0] payload;
  logic                    guard_bad;
  logic                    accept;
  logic [PHASE_W-1:0]      phase;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        merged;
  logic [ADDR_W-1:0]       addr_cnt;

  function automatic logic [ACC_W-1:0] place(input logic [PAYLOAD_BITS-1:0] p,
                                             input logic [PHASE_W-1:0]      ph);
    return ACC_W'(p) << (PAYLOAD_BITS * int'(ph));
  endfunction

  assign payload   = rx_data[PAYLOAD_BITS:1];
  assign guard_bad = rx_data[GUARD_HI] | rx_data[GUARD_LO];
  // the first byte of a pixel starts a fresh accumulator, so acc needs no reset
  assign merged    = ((phase == '0) ? '0 : acc) | place(payload, phase);

`ifdef UART_FRAME_SYNC_EN
  wr_state_t state;
  logic      is_marker;

  assign is_marker = (rx_data == FRAME_MARKER);
  assign accept    = rx_valid && (state == COLLECT) && !is_marker && !guard_bad;
`else
  assign accept    = rx_valid && !guard_bad;
`endif

  always_ff @(posedge clk) begin
    if (accept) acc <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      guard_err  <= 1'b0;
      rd_bank    <= 1'b1;
      phase      <= '0;
      addr_cnt   <= '0;
`ifdef UART_FRAME_SYNC_EN
      state      <= SYNC;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      guard_err  <= 1'b0;
      wr_addr    <= addr_cnt;

      // banks swap only after the final pixel of a complete frame was written
      if (frame_done) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end

      if (rx_valid) begin
`ifdef UART_FRAME_SYNC_EN
        if (state == SYNC) begin
          if (is_marker) state <= COLLECT;
        end else if (is_marker) begin
          phase    <= '0;
          addr_cnt <= '0;
          wr_addr  <= '0;
        end else if (guard_bad) begin
          guard_err <= 1'b1;
        end
`else
        if (guard_bad) guard_err <= 1'b1;
`endif
      end

      if (accept) begin
        if (phase == LAST_PHASE) begin
          phase   <= '0;
          wr_en   <= 1'b1;
          wr_data <= merged[PIXEL_BITS-1:0];
          if (addr_cnt == LAST_ADDR) begin
            addr_cnt   <= '0;
            frame_done <= 1'b1;
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
          end
        end else begin
          phase <= phase + PHASE_W'(1);
        end
      end
    end
  end

  frame_read_addr_gen #(
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .SCALE      (SCALE),
    .COL_MAJOR  (COL_MAJOR),
    .ADDR_W     (ADDR_W),
    .COORD_W    (COORD_W),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_read (
    .clk     (clk),
    .reset   (reset),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pix_out (pix_out)
  );

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed, table-driven bench for uart_frame_writer (reduced 16x12 frame,
// SCALE=2, column-major); adapts to UART_FRAME_SYNC_EN when defined.
module tb_uart_frame_writer;

  localparam int FW = 16;
  localparam int FH = 12;
  localparam int SC = 2;
  localparam int AW = 18;
  localparam int CW = 11;
  localparam int PB = 12;
  localparam int NW = 6;
  localparam int NR = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          wr_en, wr_bank, frame_done, guard_err, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [PB-1:0] wr_data, pix_out;
  logic [CW-1:0] pix_x = '0, pix_y = '0;
  logic [PB-1:0] rd_data = '0;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0, ge_cnt = 0, wr_cnt = 0;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] data;
  } wvec_t;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          win;
    logic [AW-1:0] addr;
  } rvec_t;

  wvec_t wv[NW];
  rvec_t rv[NR];

  always #5 clk = ~clk;

  uart_frame_writer #(
    .PIXEL_BITS   (PB),
    .PAYLOAD_BITS (6),
    .FRAME_W      (FW),
    .FRAME_H      (FH),
    .SCALE        (SC),
    .COL_MAJOR    (1),
    .ADDR_W       (AW),
    .COORD_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .guard_err  (guard_err),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_out    (pix_out)
  );

  function automatic logic [PB-1:0] ram(input logic [AW-1:0] a);
    return PB'(a) ^ 12'h5A5;
  endfunction

  // 1-cycle synchronous RAM model with address-derived contents
  always @(posedge clk) rd_data <= ram(rd_addr);

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (guard_err)  ge_cnt <= ge_cnt + 1;
    if (wr_en)      wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // called at a negedge; presents one byte for one rising edge
  task automatic tick(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset(input bit sync);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    if (sync) begin
`ifdef UART_FRAME_SYNC_EN
      tick(8'hFF);
`endif
    end
  endtask

  initial begin
    int fd0, ge0, wr0;
    logic [PB-1:0] exp_pix;

    wv[0] = '{8'h7E, 8'h02, 12'h07F};
    wv[1] = '{8'h02, 8'h04, 12'h081};
    wv[2] = '{8'h00, 8'h00, 12'h000};
    wv[3] = '{8'h7E, 8'h7E, 12'hFFF};
    wv[4] = '{8'h2A, 8'h54, 12'hA95};
    wv[5] = '{8'h40, 8'h02, 12'h060};

    rv[0]  = '{11'd5,   11'd7,  1'b1, 18'd27};
    rv[1]  = '{11'd40,  11'd7,  1'b0, 18'd0};
    rv[2]  = '{11'd0,   11'd0,  1'b1, 18'd0};
    rv[3]  = '{11'd31,  11'd23, 1'b1, 18'd191};
    rv[4]  = '{11'd31,  11'd24, 1'b0, 18'd0};
    rv[5]  = '{11'd32,  11'd0,  1'b0, 18'd0};
    rv[6]  = '{11'd640, 11'd0,  1'b0, 18'd0};
    rv[7]  = '{11'd1,   11'd1,  1'b1, 18'd0};
    rv[8]  = '{11'd2,   11'd0,  1'b1, 18'd12};
    rv[9]  = '{11'd0,   11'd2,  1'b1, 18'd1};
    rv[10] = '{11'd3,   11'd5,  1'b1, 18'd14};

    // reset values, sampled while reset is held
    repeat (3) @(negedge clk);
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_wr_bank",    32'(wr_bank),    32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_wr_data",    32'(wr_data),    32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_guard_err",  32'(guard_err),  32'd0);
    chk("rst_rd_bank",    32'(rd_bank),    32'd1);
    chk("rst_rd_addr",    32'(rd_addr),    32'd0);
    chk("rst_pix_out",    32'(pix_out),    32'd0);
    do_reset(1'b1);

    // back-to-back pixel vectors
    for (int i = 0; i < NW; i++) begin
      tick(wv[i].b0);
      chk("vec_wr_en_first_byte", 32'(wr_en), 32'd0);
      tick(wv[i].b1);
      chk("vec_wr_en",   32'(wr_en),   32'd1);
      chk("vec_wr_addr", 32'(wr_addr), 32'(i));
      chk("vec_wr_data", 32'(wr_data), 32'(wv[i].data));
    end
    @(negedge clk);
    chk("vec_wr_en_one_cycle", 32'(wr_en),   32'd0);
    chk("vec_next_addr",       32'(wr_addr), 32'(NW));

    // guard-violating byte between the two halves of a pixel
    do_reset(1'b1);
    ge0 = ge_cnt;
    tick(8'h7E);
    tick(8'h81);
    chk("guard_err_pulse",   32'(guard_err), 32'd1);
    chk("guard_no_write",    32'(wr_en),     32'd0);
    tick(8'h02);
    chk("guard_err_cleared", 32'(guard_err), 32'd0);
    chk("guard_wr_en",       32'(wr_en),     32'd1);
    chk("guard_wr_addr",     32'(wr_addr),   32'd0);
    chk("guard_wr_data",     32'(wr_data),   32'h07F);
    @(negedge clk);
    chk("guard_err_count", 32'(ge_cnt - ge0), 32'd1);

`ifdef UART_FRAME_SYNC_EN
    // marker from SYNC, then marker discarding partial pixel / partial frame
    do_reset(1'b0);
    ge0 = ge_cnt;
    tick(8'h7E);
    chk("sync_ignores_byte", 32'(wr_en), 32'd0);
    tick(8'hFF);
    tick(8'h02);
    tick(8'h04);
    chk("sync_wr_en",       32'(wr_en),      32'd1);
    chk("sync_wr_addr",     32'(wr_addr),    32'd0);
    chk("sync_wr_data",     32'(wr_data),    32'h081);
    chk("sync_frame_done",  32'(frame_done), 32'd0);
    tick(8'h02);
    tick(8'h04);
    chk("sync_second_addr", 32'(wr_addr), 32'd1);
    tick(8'h7E);
    tick(8'hFF);
    chk("marker_no_write",  32'(wr_en),   32'd0);
    tick(8'h7E);
    tick(8'h02);
    chk("marker_restart_addr", 32'(wr_addr),    32'd0);
    chk("marker_restart_data", 32'(wr_data),    32'h07F);
    chk("marker_bank",         32'(wr_bank),    32'd0);
    chk("marker_no_guard",     32'(ge_cnt - ge0), 32'd0);
`else
    // without resync support the marker is just a guard violation
    do_reset(1'b1);
    tick(8'h7E);
    tick(8'hFF);
    chk("ff_guard_err", 32'(guard_err), 32'd1);
    chk("ff_no_write",  32'(wr_en),     32'd0);
    tick(8'h02);
    chk("ff_wr_en",     32'(wr_en),     32'd1);
    chk("ff_wr_addr",   32'(wr_addr),   32'd0);
    chk("ff_wr_data",   32'(wr_data),   32'h07F);
`endif

    // full frame: done pulse on the last address, then bank swap
    do_reset(1'b1);
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    for (int p = 0; p < FW * FH - 1; p++) begin
      tick(8'h02);
      tick(8'h04);
    end
    tick(8'h02);
    tick(8'h04);
    chk("frame_last_wr_en", 32'(wr_en),      32'd1);
    chk("frame_last_addr",  32'(wr_addr),    32'(FW * FH - 1));
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_bank_hold",  32'(wr_bank),    32'd0);
    @(negedge clk);
    chk("frame_done_clear", 32'(frame_done), 32'd0);
    chk("frame_addr_wrap",  32'(wr_addr),    32'd0);
    chk("frame_wr_bank",    32'(wr_bank),    32'd1);
    chk("frame_rd_bank",    32'(rd_bank),    32'd0);
    @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    chk("frame_write_count", 32'(wr_cnt - wr0), 32'(FW * FH));

    // reset in the middle of a frame with a partial pixel pending
    tick(8'h02);
    tick(8'h04);
    tick(8'h7E);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en",   32'(wr_en),   32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_bank", 32'(wr_bank), 32'd0);
    chk("midrst_rd_bank", 32'(rd_bank), 32'd1);
    reset = 1'b0;
`ifdef UART_FRAME_SYNC_EN
    tick(8'hFF);
`endif
    tick(8'h02);
    tick(8'h04);
    chk("midrst_wr_data_fresh", 32'(wr_data), 32'h081);
    chk("midrst_addr_fresh",    32'(wr_addr), 32'd0);

    // read path: one coordinate per cycle, rd_addr +2, pix_out +4 negedges
    for (int i = 0; i < NR + 4; i++) begin
      if (i >= 2 && i - 2 < NR)
        chk("rd_addr", 32'(rd_addr), 32'(rv[i-2].win ? rv[i-2].addr : '0));
      if (i >= 4) begin
        exp_pix = rv[i-4].win ? ram(rv[i-4].addr) : '0;
        chk("pix_out", 32'(pix_out), 32'(exp_pix));
      end
      if (i < NR) begin
        pix_x = rv[i].x;
        pix_y = rv[i].y;
      end else begin
        pix_x = 11'd700;
        pix_y = 11'd0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
